port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: req  input  5  per-input-port request for this output, from that input's route computation; bit index N=0,E=1,W=2,S=3,L=4.
REQ-004 SHALL have port: valid  input  5  per-input flit available (input buffer not empty), same bit order.
REQ-005 SHALL have port: flit_id  input  15  packed 5x3-bit flit type per input, input i at [3i+2:3i].
REQ-006 SHALL have port: ready  input  1  downstream can accept one flit this cycle.
REQ-007 SHALL have port: grant  output  5  one-hot or zero, registered, selects crossbar input.
REQ-008 SHALL have port: sel  output  3  binary index of granted input, 0 when idle.
REQ-009 SHALL have port: busy  output  1  high while a packet holds the output.
REQ-010 SHALL have port: xfer  output  1  combinational pulse, one flit moves this cycle (busy & valid[sel] & ready).

Function
REQ-011 SHALL implement states IDLE and LOCKED.
REQ-012 IDLE: if (req & valid) != 0 and the selected flit_id == HEADER, SHALL pick one winner, load grant/sel, go LOCKED; grant visible the next cycle (latency 1).
REQ-013 IDLE: requests whose flit_id != HEADER SHALL be ignored (not eligible).
REQ-014 LOCKED: grant/sel SHALL stay constant until a TAIL flit transfers, independent of req (req may drop when the upstream buffer runs empty mid-packet).
REQ-015 LOCKED: xfer SHALL assert only when valid[sel] & ready; ready low or valid[sel] low SHALL stall without changing state.
REQ-016 On xfer with flit_id[sel] == TAIL, SHALL clear grant, sel, busy next cycle and enter IDLE; one idle bubble cycle precedes the next grant.
REQ-017 On xfer with HEADER while LOCKED (malformed packet), SHALL stay LOCKED to the same input.
REQ-018 Priority pointer SHALL update only on TAIL transfer, to (winner+1) mod 5.
REQ-019 grant SHALL never have more than one bit set.

Reset
REQ-020 rst low SHALL immediately force grant=0, sel=0, busy=0, state IDLE, pointer=0 (N), regardless of clock.
REQ-021 Reset asserted mid-packet SHALL abandon the lock; after release, arbitration restarts from IDLE with no memory of the prior packet.
REQ-022 xfer SHALL be 0 while rst is low.

Configuration
REQ-023 Macro PORT_ARB_RR_EN defined: winner SHALL be the first eligible input at or after the pointer, wrapping 4->0.
REQ-024 PORT_ARB_RR_EN undefined: winner SHALL be fixed priority L > N > E > W > S; pointer register SHALL not exist.

Structure
REQ-025 Shared package noc_pkg SHALL hold flit type constants (HEADER, PAYLOAD, TAIL, 3-bit), port index constants N/E/W/S/L, port count 5, and the arbiter state enum.
REQ-026 Winner selection SHALL be a combinational sub-module rr_pick (eligible vector + pointer -> one-hot winner + index); port_arbiter holds FSM, lock, and pointer.

Verification
REQ-027 Reset: rst low during LOCKED with grant=5'b00010 -> grant=0, busy=0 without clock edge; first HEADER after release granted one cycle later.
REQ-028 Single packet: input E header, 3 payloads, tail with ready=1 -> grant=5'b00010 from cycle 1, xfer 5 cycles, grant=0 cycle after tail.
REQ-029 Contention (RR on, pointer 0): N and S headers simultaneously -> N granted; after N tail and bubble, S granted with N still requesting.
REQ-030 Stall: ready low 4 cycles mid-packet -> xfer=0, grant unchanged; resumes on ready high with no flit lost.
REQ-031 Req drop: winner req and valid low 3 cycles mid-packet, W header pending -> W not granted until holder's tail transfers.
REQ-032 Fixed priority (macro undefined): L and N headers together, repeated 3 packets -> L granted every time.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC constants: flit types, port indices, arbiter state
//
// Contents:
//   NUM_PORTS        number of router ports (5)
//   PORT_N..PORT_L   port indices N=0, E=1, W=2, S=3, L=4
//   HEADER/PAYLOAD/TAIL  3-bit flit type codes
//   arb_state_t      output arbiter state (IDLE, LOCKED)
//   next_port()      (p+1) mod NUM_PORTS
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] TAIL    = 3'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p == PORT_L) ? PORT_N : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner selection among eligible inputs
//
// Ports:
//   eligible [4:0]  inputs that may win this cycle
//   ptr      [2:0]  round-robin start position (ignored in fixed priority)
//   onehot   [4:0]  one-hot winner, zero when nothing eligible
//   idx      [2:0]  binary index of winner, 0 when nothing eligible
//   any             at least one input eligible
//
// Macro PORT_ARB_RR_EN: defined -> first eligible at or after ptr, wrapping
// 4->0; undefined -> fixed priority L > N > E > W > S.
module rr_pick
    import noc_pkg::*;
(
    input  logic [4:0] eligible,
    input  logic [2:0] ptr,
    output logic [4:0] onehot,
    output logic [2:0] idx,
    output logic       any
);

`ifdef PORT_ARB_RR_EN
    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                idx         = 3'(cand);
                onehot      = 5'b00001 << cand;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b1;
        if (eligible[PORT_L])      idx = PORT_L;
        else if (eligible[PORT_N]) idx = PORT_N;
        else if (eligible[PORT_E]) idx = PORT_E;
        else if (eligible[PORT_W]) idx = PORT_W;
        else if (eligible[PORT_S]) idx = PORT_S;
        else                       any = 1'b0;
        if (any) onehot = 5'b00001 << idx;
    end
`endif

endmodule

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - NoC output-port arbiter with per-packet lock
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   req     [4:0]  per-input request for this output (N,E,W,S,L)
//   valid   [4:0]  per-input flit available
//   flit_id [14:0] per-input flit type, input i at [3i+2:3i]
//   ready          downstream accepts one flit this cycle
//   grant   [4:0]  registered one-hot grant, zero when idle
//   sel     [2:0]  binary index of granted input, 0 when idle
//   busy           a packet holds the output
//   xfer           combinational: one flit moves this cycle
//
// Macro PORT_ARB_RR_EN: defined -> round-robin with a pointer register that
// advances past the winner on each tail transfer; undefined -> fixed
// priority L > N > E > W > S and no pointer register.
module port_arbiter
    import noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [4:0]  valid,
    input  logic [14:0] flit_id,
    input  logic        ready,
    output logic [4:0]  grant,
    output logic [2:0]  sel,
    output logic        busy,
    output logic        xfer
);

    arb_state_t state;
    logic [4:0] eligible;
    logic [4:0] pick_onehot;
    logic [2:0] pick_idx;
    logic       pick_any;
    logic [2:0] cur_type;
    logic       cur_valid;

`ifdef PORT_ARB_RR_EN
    logic [2:0] ptr;
`else
    localparam logic [2:0] ptr = PORT_N;
`endif

    // Only a header at the head of an input buffer may open a new packet.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req[i] & valid[i] & (flit_id[3*i +: 3] == HEADER);
        end
    end

    rr_pick u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // Mux the held input through the one-hot grant; no out-of-range index
    // is possible and both terms are zero when idle.
    always_comb begin
        cur_type  = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                cur_type  = cur_type | flit_id[3*i +: 3];
                cur_valid = cur_valid | valid[i];
            end
        end
    end

    // req is deliberately absent: the lock survives an upstream buffer
    // running dry mid-packet.
    assign xfer = rst & busy & cur_valid & ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            busy  <= 1'b0;
`ifdef PORT_ARB_RR_EN
            ptr   <= PORT_N;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_onehot;
                        sel   <= pick_idx;
                        busy  <= 1'b1;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    // A stray header mid-packet keeps the lock; only a tail
                    // releases it, leaving one idle bubble before re-arbitration.
                    if (xfer && (cur_type == TAIL)) begin
                        grant <= '0;
                        sel   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef PORT_ARB_RR_EN
                        ptr   <= next_port(sel);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - directed self-checking bench for port_arbiter
module tb_port_arbiter;
    import noc_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  valid;
    logic [14:0] flit_id;
    logic        ready;
    logic [4:0]  grant;
    logic [2:0]  sel;
    logic        busy;
    logic        xfer;

    int vectors;
    int miscompares;

    port_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .valid   (valid),
        .flit_id (flit_id),
        .ready   (ready),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .xfer    (xfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic v, input logic [2:0] t);
        req[p]           = r;
        valid[p]         = v;
        flit_id[3*p +: 3] = t;
    endtask

    localparam logic [4:0] G_N = 5'b00001;
    localparam logic [4:0] G_E = 5'b00010;
    localparam logic [4:0] G_W = 5'b00100;
    localparam logic [4:0] G_S = 5'b01000;
    localparam logic [4:0] G_L = 5'b10000;

    int         nx;
    int         pos;
    int         done_at;
    int         wp;
    logic [4:0] wexp;
    logic [2:0] stype [4];
    int         fwin  [3];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        req     = '0;
        valid   = '0;
        flit_id = '0;
        ready   = 1'b1;

        // Reset state
        #3;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sel",   32'(sel),   0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_xfer",  32'(xfer),  0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Single packet from E: header, 3 payloads, tail
        set_port(int'(PORT_E), 1'b1, 1'b1, HEADER);
        #1;
        chk("pkt_pre_grant", 32'(grant), 0);
        chk("pkt_pre_xfer",  32'(xfer),  0);
        cyc();
        chk("pkt_grant", 32'(grant), 32'(G_E));
        chk("pkt_sel",   32'(sel),   1);
        chk("pkt_busy",  32'(busy),  1);
        nx = 0;
        for (int k = 0; k < 5; k++) begin
            set_port(int'(PORT_E), 1'b1, 1'b1, (k == 0) ? HEADER : ((k == 4) ? TAIL : PAYLOAD));
            #1;
            if (xfer) nx++;
            chk("pkt_grant_hold", 32'(grant), 32'(G_E));
            cyc();
        end
        set_port(int'(PORT_E), 1'b0, 1'b0, 3'd0);
        chk("pkt_xfer_count", 32'(nx), 5);
        chk("pkt_end_grant", 32'(grant), 0);
        chk("pkt_end_busy",  32'(busy),  0);
        chk("pkt_end_sel",   32'(sel),   0);
        cyc();

        // Reset mid-packet, without a clock edge
        set_port(int'(PORT_E), 1'b1, 1'b1, HEADER);
        cyc();
        chk("mrst_locked", 32'(grant), 32'(G_E));
        set_port(int'(PORT_E), 1'b1, 1'b1, PAYLOAD);
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_grant", 32'(grant), 0);
        chk("mrst_busy",  32'(busy),  0);
        chk("mrst_xfer",  32'(xfer),  0);
        cyc();
        rst = 1'b1;
        set_port(int'(PORT_E), 1'b1, 1'b1, HEADER);
        #1;
        chk("mrst_rel_idle", 32'(grant), 0);
        cyc();
        chk("mrst_regrant", 32'(grant), 32'(G_E));
        set_port(int'(PORT_E), 1'b1, 1'b1, TAIL);
        #1;
        chk("mrst_tail_xfer", 32'(xfer), 1);
        cyc();
        set_port(int'(PORT_E), 1'b0, 1'b0, 3'd0);
        chk("mrst_tail_clear", 32'(grant), 0);

        // Contention N vs S, starting from a fresh reset (pointer at N)
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        set_port(int'(PORT_N), 1'b1, 1'b1, HEADER);
        set_port(int'(PORT_S), 1'b1, 1'b1, HEADER);
        cyc();
        chk("cont_first", 32'(grant), 32'(G_N));
        set_port(int'(PORT_N), 1'b1, 1'b1, TAIL);
        #1;
        chk("cont_n_tail", 32'(xfer), 1);
        cyc();
        set_port(int'(PORT_N), 1'b1, 1'b1, HEADER);
        chk("cont_bubble", 32'(grant), 0);
        cyc();
`ifdef PORT_ARB_RR_EN
        wexp = G_S;
        wp   = int'(PORT_S);
`else
        wexp = G_N;
        wp   = int'(PORT_N);
`endif
        chk("cont_second", 32'(grant), 32'(wexp));
        set_port(wp, 1'b1, 1'b1, TAIL);
        #1;
        chk("cont_second_xfer", 32'(xfer), 1);
        cyc();
        set_port(int'(PORT_N), 1'b0, 1'b0, 3'd0);
        set_port(int'(PORT_S), 1'b0, 1'b0, 3'd0);
        chk("cont_clear", 32'(grant), 0);
        cyc();

        // Stall: ready low 4 cycles mid-packet, no flit lost
        stype[0] = HEADER;
        stype[1] = PAYLOAD;
        stype[2] = PAYLOAD;
        stype[3] = TAIL;
        set_port(int'(PORT_E), 1'b1, 1'b1, HEADER);
        cyc();
        chk("stall_grant", 32'(grant), 32'(G_E));
        pos     = 0;
        done_at = -1;
        for (int c = 0; c < 10; c++) begin
            ready = !(c >= 2 && c <= 5);
            if (pos < 4) set_port(int'(PORT_E), 1'b1, 1'b1, stype[pos]);
            else         set_port(int'(PORT_E), 1'b0, 1'b0, 3'd0);
            #1;
            if (!ready) begin
                chk("stall_xfer",  32'(xfer),  0);
                chk("stall_grant_hold", 32'(grant), 32'(G_E));
            end
            if (xfer) begin
                pos++;
                if (pos == 4) done_at = c;
            end
            cyc();
        end
        ready = 1'b1;
        set_port(int'(PORT_E), 1'b0, 1'b0, 3'd0);
        chk("stall_flits", 32'(pos), 4);
        chk("stall_tail_cycle", 32'(done_at), 7);
        chk("stall_end_grant", 32'(grant), 0);

        // Holder's req/valid drop mid-packet while W header waits
        set_port(int'(PORT_N), 1'b1, 1'b1, HEADER);
        cyc();
        chk("drop_grant", 32'(grant), 32'(G_N));
        cyc();
        set_port(int'(PORT_N), 1'b1, 1'b1, PAYLOAD);
        cyc();
        for (int c = 0; c < 3; c++) begin
            set_port(int'(PORT_N), 1'b0, 1'b0, 3'd0);
            set_port(int'(PORT_W), 1'b1, 1'b1, HEADER);
            #1;
            chk("drop_hold", 32'(grant), 32'(G_N));
            chk("drop_xfer", 32'(xfer),  0);
            cyc();
        end
        chk("drop_hold_after", 32'(grant), 32'(G_N));
        set_port(int'(PORT_N), 1'b1, 1'b1, TAIL);
        #1;
        chk("drop_tail_xfer", 32'(xfer), 1);
        cyc();
        set_port(int'(PORT_N), 1'b0, 1'b0, 3'd0);
        chk("drop_bubble", 32'(grant), 0);
        cyc();
        chk("drop_w_grant", 32'(grant), 32'(G_W));
        chk("drop_w_sel",   32'(sel),   2);
        set_port(int'(PORT_W), 1'b1, 1'b1, TAIL);
        cyc();
        set_port(int'(PORT_W), 1'b0, 1'b0, 3'd0);
        chk("drop_w_clear", 32'(grant), 0);
        cyc();

        // L and N headers together, three back-to-back packets
`ifdef PORT_ARB_RR_EN
        fwin[0] = int'(PORT_L);
        fwin[1] = int'(PORT_N);
        fwin[2] = int'(PORT_L);
`else
        fwin[0] = int'(PORT_L);
        fwin[1] = int'(PORT_L);
        fwin[2] = int'(PORT_L);
`endif
        set_port(int'(PORT_L), 1'b1, 1'b1, HEADER);
        set_port(int'(PORT_N), 1'b1, 1'b1, HEADER);
        for (int p = 0; p < 3; p++) begin
            cyc();
            wexp = (fwin[p] == int'(PORT_L)) ? G_L : G_N;
            chk("prio_grant", 32'(grant), 32'(wexp));
            set_port(fwin[p], 1'b1, 1'b1, TAIL);
            #1;
            chk("prio_tail_xfer", 32'(xfer), 1);
            cyc();
            set_port(fwin[p], 1'b1, 1'b1, HEADER);
            chk("prio_bubble", 32'(grant), 0);
        end
        set_port(int'(PORT_L), 1'b0, 1'b0, 3'd0);
        set_port(int'(PORT_N), 1'b0, 1'b0, 3'd0);
        cyc();
        cyc();
        chk("final_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
